// File: rtl/pe_mac_cell.sv
// Registered systolic MAC cell: double-buffered c1/c2, OS/WS dataflow, rounding shift, 1-cycle latency, no backpressure.
// Optional PE_SATURATE_EN: saturate all ACC_W-bit sums and the rounding reduction instead of wrapping.
module pe_mac_cell #(
   parameter int IN_W     = 8,
   parameter int ACC_W    = 20,
   parameter int ID_W     = 3,
   parameter int SHIFT_W  = 5,
   parameter int DATAFLOW = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [IN_W-1:0]    in_a,
   input  logic [ACC_W-1:0]   in_b,
   input  logic [ACC_W-1:0]   in_d,
   input  logic               in_dataflow,
   input  logic               in_propagate,
   input  logic [SHIFT_W-1:0] in_shift,
   input  logic [ID_W-1:0]    in_id,
   input  logic               in_last,
   output logic               out_valid,
   output logic [IN_W-1:0]    out_a,
   output logic [ACC_W-1:0]   out_b,
   output logic [ACC_W-1:0]   out_c,
   output logic               out_dataflow,
   output logic               out_propagate,
   output logic [SHIFT_W-1:0] out_shift,
   output logic [ID_W-1:0]    out_id,
   output logic               out_last,
   output logic               bad_dataflow
);

   localparam int PW = 2 * IN_W;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACC_W:0]   wide_t;

   function automatic acc_t reduce(input wide_t s);
`ifdef PE_SATURATE_EN
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
`else
      return s[ACC_W-1:0];
`endif
   endfunction

   function automatic acc_t add_acc(input acc_t x, input acc_t y);
      wide_t s;
      s = wide_t'(x) + wide_t'(y);
      return reduce(s);
   endfunction

   // Product is formed at 2*IN_W bits, then sign-extended/truncated to ACC_W.
   function automatic acc_t mul(input logic signed [IN_W-1:0] a, input acc_t b);
      logic signed [PW-1:0] ae, be, p;
      ae = PW'(a);
      be = PW'(b);
      p  = ae * be;
      return ACC_W'(p);
   endfunction

   function automatic acc_t rnd(input acc_t x, input logic [SHIFT_W-1:0] s);
      wide_t t, bias;
      if (int'(s) >= ACC_W) return x[ACC_W-1] ? '1 : '0;
      bias = '0;
      if (s != '0) bias = wide_t'(1) << (s - SHIFT_W'(1));
      t = wide_t'(x) + bias;
      t = t >>> s;
      return reduce(t);
   endfunction

   logic               valid_q, valid_d;
   logic [IN_W-1:0]    a_q, a_d;
   acc_t               b_q, b_d, c_q, c_d, c1_q, c1_d, c2_q, c2_d;
   logic               df_q, df_d, prop_q, prop_d, last_q, last_d, bad_q, bad_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               supported;

   always_comb begin
      valid_d   = in_valid;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      c1_d      = c1_q;
      c2_d      = c2_q;
      df_d      = df_q;
      prop_d    = prop_q;
      shift_d   = shift_q;
      id_d      = id_q;
      last_d    = last_q;
      bad_d     = 1'b0;
      supported = (DATAFLOW == 2) || (DATAFLOW == int'(in_dataflow));
      if (in_valid) begin
         a_d     = in_a;
         b_d     = in_b;
         df_d    = in_dataflow;
         prop_d  = in_propagate;
         shift_d = in_shift;
         id_d    = in_id;
         last_d  = in_last;
         if (!supported) begin
            bad_d = 1'b1;
            c_d   = '0;
         end else if (!in_dataflow) begin
            if (in_propagate) begin
               c_d  = rnd(c1_q, in_shift);
               c2_d = add_acc(c2_q, mul(in_a, in_b));
               c1_d = in_d;
            end else begin
               c_d  = rnd(c2_q, in_shift);
               c1_d = add_acc(c1_q, mul(in_a, in_b));
               c2_d = in_d;
            end
         end else begin
            // WS: the idle buffer holds the stationary weight.
            if (in_propagate) begin
               c_d  = c1_q;
               b_d  = add_acc(in_b, mul(in_a, c2_q));
               c1_d = in_d;
            end else begin
               c_d  = c2_q;
               b_d  = add_acc(in_b, mul(in_a, c1_q));
               c2_d = in_d;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         df_q    <= 1'b0;
         prop_q  <= 1'b0;
         shift_q <= '0;
         id_q    <= '0;
         last_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         df_q    <= df_d;
         prop_q  <= prop_d;
         shift_q <= shift_d;
         id_q    <= id_d;
         last_q  <= last_d;
         bad_q   <= bad_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_a         = a_q;
   assign out_b         = b_q;
   assign out_c         = c_q;
   assign out_dataflow  = df_q;
   assign out_propagate = prop_q;
   assign out_shift     = shift_q;
   assign out_id        = id_q;
   assign out_last      = last_q;
   assign bad_dataflow  = bad_q;

endmodule

// File: tb/tb_pe_mac_cell.sv
// Directed bench for pe_mac_cell: one full-mode instance and one OS-only instance driven in parallel.
module tb_pe_mac_cell;
   localparam int IN_W = 8, ACC_W = 20, ID_W = 3, SHIFT_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_dataflow = 1'b0, in_propagate = 1'b0, in_last = 1'b0;
   logic [IN_W-1:0]    in_a = '0;
   logic [ACC_W-1:0]   in_b = '0, in_d = '0;
   logic [SHIFT_W-1:0] in_shift = '0;
   logic [ID_W-1:0]    in_id = '0;

   logic               m_valid, m_df, m_prop, m_last, m_bad;
   logic [IN_W-1:0]    m_a;
   logic [ACC_W-1:0]   m_b, m_c;
   logic [SHIFT_W-1:0] m_shift;
   logic [ID_W-1:0]    m_id;

   logic               o_valid, o_df, o_prop, o_last, o_bad;
   logic [IN_W-1:0]    o_a;
   logic [ACC_W-1:0]   o_b, o_c;
   logic [SHIFT_W-1:0] o_shift;
   logic [ID_W-1:0]    o_id;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pe_mac_cell #(.IN_W(IN_W), .ACC_W(ACC_W), .ID_W(ID_W), .SHIFT_W(SHIFT_W), .DATAFLOW(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_d(in_d),
      .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift),
      .in_id(in_id), .in_last(in_last),
      .out_valid(m_valid), .out_a(m_a), .out_b(m_b), .out_c(m_c), .out_dataflow(m_df),
      .out_propagate(m_prop), .out_shift(m_shift), .out_id(m_id), .out_last(m_last),
      .bad_dataflow(m_bad));

   pe_mac_cell #(.IN_W(IN_W), .ACC_W(ACC_W), .ID_W(ID_W), .SHIFT_W(SHIFT_W), .DATAFLOW(0)) u_os (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_d(in_d),
      .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift),
      .in_id(in_id), .in_last(in_last),
      .out_valid(o_valid), .out_a(o_a), .out_b(o_b), .out_c(o_c), .out_dataflow(o_df),
      .out_propagate(o_prop), .out_shift(o_shift), .out_id(o_id), .out_last(o_last),
      .bad_dataflow(o_bad));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Apply one beat between edges, then sample 1 time unit after the capturing edge.
   task automatic beat(input logic v, input logic df, input logic prop, input int sh,
                       input int a, input int b, input int d, input int id = 0, input logic last = 1'b0);
      in_valid     = v;
      in_dataflow  = df;
      in_propagate = prop;
      in_shift     = SHIFT_W'(sh);
      in_a         = IN_W'(a);
      in_b         = ACC_W'(b);
      in_d         = ACC_W'(d);
      in_id        = ID_W'(id);
      in_last      = last;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_ovf;
      // 1: reset with traffic, then a mid-stream reset discards c1.
      rst = 1'b1;
      beat(1, 0, 0, 0, 5, 5, 0);
      beat(1, 0, 0, 0, 5, 5, 0);
      check("rst_valid", m_valid, 0);
      check("rst_a", $signed(m_a), 0);
      check("rst_b", $signed(m_b), 0);
      check("rst_c", $signed(m_c), 0);
      check("rst_bad", m_bad, 0);
      check("rst_ctrl", {m_df, m_prop, m_shift, m_id, m_last}, 0);
      rst = 1'b0;
      beat(1, 0, 0, 0, 5, 5, 0);
      rst = 1'b1;
      beat(1, 0, 0, 0, 5, 5, 0);
      rst = 1'b0;
      beat(1, 0, 1, 0, 0, 0, 0);
      check("rst_drain_c", $signed(m_c), 0);
      check("rst_drain_valid", m_valid, 1);

      // 2: OS accumulate 3 x (3*4) into c1, then drain.
      repeat (3) beat(1, 0, 0, 0, 3, 4, 0);
      beat(1, 0, 1, 0, 0, 0, 0, 5, 1'b1);
      check("os_drain_c", $signed(m_c), 36);
      check("os_drain_b", $signed(m_b), 0);
      check("os_id", m_id, 5);
      check("os_last", m_last, 1);
      check("os_prop", m_prop, 1);

      // 3: WS preload c1=5, bubble, then use.
      beat(1, 1, 1, 0, 0, 7, 5);
      check("ws_pre_b", $signed(m_b), 7);
      beat(0, 1, 0, 0, 7, 55, 0);
      check("ws_bubble_valid", m_valid, 0);
      check("ws_bubble_b", $signed(m_b), 7);
      check("ws_bubble_a", $signed(m_a), 0);
      beat(1, 1, 0, 0, -2, 100, 0);
      check("ws_use_b", $signed(m_b), 90);
      check("ws_use_c", $signed(m_c), 0);
      check("ws_use_df", m_df, 1);
      beat(1, 1, 1, 0, 3, 1, 0);
      check("ws_read_c1", $signed(m_c), 5);
      check("ws_b_c2", $signed(m_b), 1);

      // 4: rounding shifts on c1.
      beat(1, 0, 1, 0, 0, 0, 37);
      beat(1, 0, 1, 2, 0, 0, -6);
      check("rnd_37_s2", $signed(m_c), 9);
      beat(1, 0, 1, 2, 0, 0, -6);
      check("rnd_m6_s2", $signed(m_c), -1);
      beat(1, 0, 1, 25, 0, 0, 13);
      check("rnd_m6_s25", $signed(m_c), -1);
      beat(1, 0, 1, 0, 0, 0, 100);
      check("rnd_13_s0", $signed(m_c), 13);
      beat(1, 0, 1, 31, 0, 0, 0);
      check("rnd_100_s31", $signed(m_c), 0);

      // 5: accumulate past the positive limit.
      beat(1, 0, 1, 0, 0, 0, 524287);
      beat(1, 0, 0, 0, 1, 1, 0);
      beat(1, 0, 1, 0, 0, 0, 0);
`ifdef PE_SATURATE_EN
      exp_ovf = 524287;
`else
      exp_ovf = -524288;
`endif
      check("ovf_c", $signed(m_c), exp_ovf);

      // 6: WS beat rejected by the OS-only cell, accepted by the full cell.
      rst = 1'b1;
      beat(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      beat(1, 0, 0, 0, 2, 3, 0);
      check("rej_pre_bad", o_bad, 0);
      beat(1, 1, 1, 0, 2, 3, 99);
      check("rej_bad", o_bad, 1);
      check("rej_c", $signed(o_c), 0);
      check("rej_a", $signed(o_a), 2);
      check("rej_b", $signed(o_b), 3);
      check("rej_df", o_df, 1);
      check("rej_full_bad", m_bad, 0);
      beat(1, 0, 1, 0, 0, 0, 0);
      check("rej_after_bad", o_bad, 0);
      check("rej_c1_kept", $signed(o_c), 6);
      check("rej_full_c1", $signed(m_c), 99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
